// File: rtl/rv32i_decode_queue.sv
// RV32I instruction decoder feeding a circular queue of decoded control bundles.
// Optional build macro RV32M_DECODE_EN adds decode of the RV32M multiply group.
module rv32i_decode_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [XLEN-1:0]  out_imm,
    output logic [3:0]       out_alu_op,
    output logic [2:0]       out_funct3,
    output logic [8:0]       out_ctrl,
    output logic [1:0]       out_result_src,
    output logic [CNT_W-1:0] count
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu_op;
        logic [2:0]      funct3;
        logic [8:0]      ctrl;
        logic [1:0]      result_src;
    } entry_t;

    function automatic logic [3:0] alu_from_f3(input logic [2:0] fn, input logic alt);
        logic [3:0] op;
        case (fn)
            3'b000:  op = alt ? 4'd1 : 4'd0;
            3'b001:  op = 4'd2;
            3'b010:  op = 4'd3;
            3'b011:  op = 4'd4;
            3'b100:  op = 4'd5;
            3'b101:  op = alt ? 4'd7 : 4'd6;
            3'b110:  op = 4'd8;
            default: op = 4'd9;
        endcase
        return op;
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u  = {in_instr[31:12], 12'b0};
    assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    logic        reg_write, mem_read, mem_write, branch, jump, jalr, alu_src_imm, alu_a_pc, illegal;
    logic [3:0]  dec_alu_op;
    logic [1:0]  dec_result_src;
    logic [31:0] dec_imm;
    entry_t      dec_entry;

    // Per-opcode decode; illegal encodings leave every write/branch/jump flag clear.
    always_comb begin
        reg_write      = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        branch         = 1'b0;
        jump           = 1'b0;
        jalr           = 1'b0;
        alu_src_imm    = 1'b0;
        alu_a_pc       = 1'b0;
        illegal        = 1'b0;
        dec_alu_op     = 4'd0;
        dec_result_src = 2'd0;
        dec_imm        = 32'd0;
        case (opcode)
            OP_R: begin
                if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
                    reg_write  = 1'b1;
                    dec_alu_op = alu_from_f3(f3, f7[5]);
                end
`ifdef RV32M_DECODE_EN
                else if (f7 == 7'b0000001 && !f3[2]) begin
                    reg_write  = 1'b1;
                    dec_alu_op = 4'd10 + {2'b00, f3[1:0]};
                end
`endif
                else begin
                    illegal = 1'b1;
                end
            end
            OP_I: begin
                reg_write   = 1'b1;
                alu_src_imm = 1'b1;
                dec_imm     = imm_i;
                dec_alu_op  = alu_from_f3(f3, (f3 == 3'b101) && in_instr[30]);
            end
            OP_LOAD: begin
                if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) begin
                    reg_write      = 1'b1;
                    mem_read       = 1'b1;
                    alu_src_imm    = 1'b1;
                    dec_result_src = 2'd1;
                    dec_imm        = imm_i;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_STORE: begin
                if (!f3[2] && f3 != 3'b011) begin
                    mem_write   = 1'b1;
                    alu_src_imm = 1'b1;
                    dec_imm     = imm_s;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_BR: begin
                branch     = 1'b1;
                dec_alu_op = 4'd1;
                dec_imm    = imm_b;
            end
            OP_JAL: begin
                reg_write      = 1'b1;
                jump           = 1'b1;
                dec_result_src = 2'd2;
                dec_imm        = imm_j;
            end
            OP_JALR: begin
                reg_write      = 1'b1;
                jump           = 1'b1;
                jalr           = 1'b1;
                alu_src_imm    = 1'b1;
                dec_result_src = 2'd2;
                dec_imm        = imm_i;
            end
            OP_LUI: begin
                reg_write      = 1'b1;
                dec_result_src = 2'd3;
                dec_imm        = imm_u;
            end
            OP_AUIPC: begin
                reg_write   = 1'b1;
                alu_a_pc    = 1'b1;
                alu_src_imm = 1'b1;
                dec_imm     = imm_u;
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        dec_entry.pc         = in_pc;
        dec_entry.rd         = in_instr[11:7];
        dec_entry.rs1        = in_instr[19:15];
        dec_entry.rs2        = in_instr[24:20];
        dec_entry.imm        = XLEN'($signed(dec_imm));
        dec_entry.alu_op     = dec_alu_op;
        dec_entry.funct3     = f3;
        dec_entry.ctrl       = {reg_write, mem_read, mem_write, branch, jump, jalr,
                                alu_src_imm, alu_a_pc, illegal};
        dec_entry.result_src = dec_result_src;
    end

    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_c, pop_c;

    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push_c    = in_valid & in_ready;
    assign pop_c     = out_valid & out_ready;

    // Queue pointer/occupancy update; flush wins over any push or pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                mem_d[wr_ptr_q] = dec_entry;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_c && !push_c) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign out_pc         = mem_q[rd_ptr_q].pc;
    assign out_rd         = mem_q[rd_ptr_q].rd;
    assign out_rs1        = mem_q[rd_ptr_q].rs1;
    assign out_rs2        = mem_q[rd_ptr_q].rs2;
    assign out_imm        = mem_q[rd_ptr_q].imm;
    assign out_alu_op     = mem_q[rd_ptr_q].alu_op;
    assign out_funct3     = mem_q[rd_ptr_q].funct3;
    assign out_ctrl       = mem_q[rd_ptr_q].ctrl;
    assign out_result_src = mem_q[rd_ptr_q].result_src;
    assign count          = count_q;

endmodule

// File: tb/tb_rv32i_decode_queue.sv
// Scoreboard bench for rv32i_decode_queue: hand-decoded expectations queued on push, compared on pop.
module tb_rv32i_decode_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc, out_pc, out_imm;
    logic [4:0]       out_rd, out_rs1, out_rs2;
    logic [3:0]       out_alu_op;
    logic [2:0]       out_funct3;
    logic [8:0]       out_ctrl;
    logic [1:0]       out_result_src;
    logic [CNT_W-1:0] count;

    rv32i_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .out_alu_op(out_alu_op), .out_funct3(out_funct3), .out_ctrl(out_ctrl),
        .out_result_src(out_result_src), .count(count)
    );

    always #5 clk = ~clk;

    // full=0: only pc/regs/funct3/ctrl are defined (illegal entries)
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [8:0]  ctrl;
        logic [1:0]  rsrc;
        logic        chk_imm;
        logic        full;
    } exp_t;

    exp_t sb[$];
    exp_t exp_in;
    int   checks = 0;
    int   errors = 0;
    bit   acc = 1'b0;
    bit   rnd = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] imm,
                                input logic [3:0] alu, input logic [8:0] ctrl, input logic [1:0] rsrc,
                                input logic chk_imm, input logic full);
        exp_t e;
        e.instr = instr; e.pc = pc; e.imm = imm; e.alu = alu;
        e.ctrl = ctrl; e.rsrc = rsrc; e.chk_imm = chk_imm; e.full = full;
        return e;
    endfunction

    // Reference model: occupancy = scoreboard size; compare head on each pop.
    always @(negedge clk) begin
        exp_t e;
        bit   exp_ready;
        acc = 1'b0;
        if (rst) begin
            sb.delete();
        end else begin
            exp_ready = (sb.size() != DEPTH);
            check("in_ready", 64'(in_ready), 64'(exp_ready));
            check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
            check("count", 64'(count), 64'(sb.size()));
            if (flush) begin
                sb.delete();
            end else begin
                if (out_ready && sb.size() != 0) begin
                    e = sb.pop_front();
                    check("pc", 64'(out_pc), 64'(e.pc));
                    check("rd", 64'(out_rd), 64'(e.instr[11:7]));
                    check("rs1", 64'(out_rs1), 64'(e.instr[19:15]));
                    check("rs2", 64'(out_rs2), 64'(e.instr[24:20]));
                    check("funct3", 64'(out_funct3), 64'(e.instr[14:12]));
                    check("ctrl", 64'(out_ctrl), 64'(e.ctrl));
                    if (e.full) begin
                        check("alu_op", 64'(out_alu_op), 64'(e.alu));
                        check("result_src", 64'(out_result_src), 64'(e.rsrc));
                        if (e.chk_imm) check("imm", 64'(out_imm), 64'(e.imm));
                    end
                end
                if (in_valid && exp_ready) begin
                    sb.push_back(exp_in);
                    acc = 1'b1;
                end
            end
        end
    end

    task automatic push_item(input exp_t e);
        in_valid = 1'b1; in_instr = e.instr; in_pc = e.pc; exp_in = e;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        check("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                @(posedge clk); #1;
                return;
            end
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0; exp_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_pc", 64'(out_pc), 64'd0);
        check("rst_imm", 64'(out_imm), 64'd0);
        check("rst_ctrl", 64'(out_ctrl), 64'd0);
        check("rst_alu", 64'(out_alu_op), 64'd0);
        @(posedge clk); #1;

        // addi x1,x0,-5
        out_ready = 1'b1;
        push_item(mk(32'hFFB00093, 32'h0, 32'hFFFFFFFB, 4'd0, 9'h104, 2'd0, 1'b1, 1'b1));
        @(negedge clk);
        check("addi_latency_valid", 64'(out_valid), 64'd1);
        drain();

        // Fill to DEPTH with no consumer, then offer a fifth that must be refused.
        out_ready = 1'b0;
        push_item(mk(32'h00208463, 32'h100, 32'h8, 4'd1, 9'h020, 2'd0, 1'b1, 1'b1));
        push_item(mk(32'h0080006F, 32'h104, 32'h8, 4'd0, 9'h110, 2'd2, 1'b1, 1'b1));
        push_item(mk(32'h407302B3, 32'h108, 32'h0, 4'd1, 9'h100, 2'd0, 1'b0, 1'b1));
        push_item(mk(32'h40315093, 32'h10C, 32'h403, 4'd7, 9'h104, 2'd0, 1'b1, 1'b1));
        in_valid = 1'b1; in_instr = 32'h123453B7; in_pc = 32'h110;
        exp_in = mk(32'h123453B7, 32'h110, 32'h12345000, 4'd0, 9'h100, 2'd3, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("full_count", 64'(count), 64'(DEPTH));
        check("full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Mixed stream with random backpressure.
        rnd = 1'b1;
        push_item(mk(32'hFFC12203, 32'h200, 32'hFFFFFFFC, 4'd0, 9'h184, 2'd1, 1'b1, 1'b1));
        push_item(mk(32'h00512423, 32'h204, 32'h8, 4'd0, 9'h044, 2'd0, 1'b1, 1'b1));
        push_item(mk(32'h123453B7, 32'h208, 32'h12345000, 4'd0, 9'h100, 2'd3, 1'b1, 1'b1));
        push_item(mk(32'h00001097, 32'h20C, 32'h1000, 4'd0, 9'h106, 2'd0, 1'b1, 1'b1));
        push_item(mk(32'h004280E7, 32'h210, 32'h4, 4'd0, 9'h11C, 2'd2, 1'b1, 1'b1));
        push_item(mk(32'h0000007F, 32'h214, 32'h0, 4'd0, 9'h001, 2'd0, 1'b0, 1'b0));
        push_item(mk(32'h0000B083, 32'h218, 32'h0, 4'd0, 9'h001, 2'd0, 1'b0, 1'b0));
        push_item(mk(32'h00513423, 32'h21C, 32'h0, 4'd0, 9'h001, 2'd0, 1'b0, 1'b0));
`ifdef RV32M_DECODE_EN
        push_item(mk(32'h022081B3, 32'h220, 32'h0, 4'd10, 9'h100, 2'd0, 1'b0, 1'b1));
`else
        push_item(mk(32'h022081B3, 32'h220, 32'h0, 4'd0, 9'h001, 2'd0, 1'b0, 1'b0));
`endif
        rnd = 1'b0;
        drain();

        // Flush with three queued and a simultaneous push.
        out_ready = 1'b0;
        push_item(mk(32'h00100093, 32'h300, 32'h1, 4'd0, 9'h104, 2'd0, 1'b1, 1'b1));
        push_item(mk(32'h00200093, 32'h304, 32'h2, 4'd0, 9'h104, 2'd0, 1'b1, 1'b1));
        push_item(mk(32'h00300093, 32'h308, 32'h3, 4'd0, 9'h104, 2'd0, 1'b1, 1'b1));
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00400093; in_pc = 32'h999;
        exp_in = mk(32'h00400093, 32'h999, 32'h4, 4'd0, 9'h104, 2'd0, 1'b1, 1'b1);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        push_item(mk(32'h00500093, 32'h400, 32'h5, 4'd0, 9'h104, 2'd0, 1'b1, 1'b1));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
